// File: rtl/ahb_lite_master_if.sv
// Command/response stream and AHB-Lite bus signals of ahb_lite_master.
// The master modport is the initiator's view; the slave modport is the far side.
interface ahb_lite_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-master AHB-Lite initiator: valid/ready commands become SINGLE transfers,
// with the address phase of the next command overlapping the current data phase.
module ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_lite_master_if.master bus
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic [1:0]  ap_size;
  logic [1:0]  ap_lane;
  logic [31:0] ap_wdata;
  logic        dp_valid;
  logic        dp_write;
  logic [1:0]  dp_size;
  logic [1:0]  dp_lane;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_lanes;
  logic [31:0] rd_byte_sh;
  logic [31:0] rd_half_sh;

  assign bus.cmd_ready = bus.HREADY;
  assign bus.busy      = (bus.HTRANS == TRANS_NONSEQ) | dp_valid;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;

  always_comb begin
    wdata_lanes = ap_wdata;
    case (ap_size)
      2'b00:   wdata_lanes = {4{ap_wdata[7:0]}};
      2'b01:   wdata_lanes = {2{ap_wdata[15:0]}};
      default: wdata_lanes = ap_wdata;
    endcase
  end

  assign rd_byte_sh = bus.HRDATA >> {dp_lane, 3'b000};
  assign rd_half_sh = bus.HRDATA >> {dp_lane[1], 4'b0000};

  always_comb begin
    rdata_lanes = bus.HRDATA;
    case (dp_size)
      2'b00:   rdata_lanes = {24'h0, rd_byte_sh[7:0]};
      2'b01:   rdata_lanes = {16'h0, rd_half_sh[15:0]};
      default: rdata_lanes = bus.HRDATA;
    endcase
  end

  // Address phase: only moves when the bus is ready, so it holds through wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.HADDR  <= 32'h0;
      bus.HTRANS <= TRANS_IDLE;
      bus.HWRITE <= 1'b0;
      bus.HSIZE  <= 3'b000;
      ap_size    <= 2'b00;
      ap_lane    <= 2'b00;
      ap_wdata   <= 32'h0;
    end else if (bus.HREADY) begin
      if (bus.cmd_valid) begin
        bus.HADDR  <= bus.cmd_addr;
        bus.HTRANS <= TRANS_NONSEQ;
        bus.HWRITE <= bus.cmd_write;
        bus.HSIZE  <= {1'b0, bus.cmd_size[1] ? 2'b10 : bus.cmd_size};
        ap_size    <= bus.cmd_size;
        ap_lane    <= bus.cmd_addr[1:0];
        ap_wdata   <= bus.cmd_wdata;
      end else begin
        bus.HTRANS <= TRANS_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      dp_size    <= 2'b00;
      dp_lane    <= 2'b00;
      bus.HWDATA <= 32'h0;
    end else if (bus.HREADY) begin
      dp_valid <= (bus.HTRANS == TRANS_NONSEQ);
      if (bus.HTRANS == TRANS_NONSEQ) begin
        dp_write   <= bus.HWRITE;
        dp_size    <= ap_size;
        dp_lane    <= ap_lane;
        bus.HWDATA <= wdata_lanes;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= dp_valid & bus.HREADY;
      if (dp_valid && bus.HREADY) begin
        bus.rsp_write <= dp_write;
        bus.rsp_err   <= bus.HRESP;
        bus.rsp_rdata <= dp_write ? 32'h0 : rdata_lanes;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: directed scenarios plus random traffic, scored against
// a transaction-level model of accepted commands and expected responses.
module tb_ahb_lite_master;

  logic HCLK;
  logic HRESETn;

  ahb_lite_master_if bus ();

  ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  int checks = 0;
  int errors = 0;

  cmd_t        ap_q[$];
  logic        dp_has;
  cmd_t        dp_cmd;
  logic        rsp_has;
  logic        rsp_w;
  logic        rsp_e;
  logic [31:0] rsp_d;
  int          step_no;
  int          first_acc;
  int          last_rsp;
  logic        obs_err[$];
  logic        obs_write[$];
  logic [31:0] obs_rdata[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_hsize(input logic [1:0] s);
    return s[1] ? 3'b010 : {1'b0, s};
  endfunction

  function automatic logic [31:0] lanes(input logic [1:0] s, input logic [31:0] w);
    if (s == 2'b00) return {4{w[7:0]}};
    if (s == 2'b01) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    if (s == 2'b00) return (d >> (8 * a[1:0])) & 32'h0000_00FF;
    if (s == 2'b01) return (d >> (16 * a[1])) & 32'h0000_FFFF;
    return d;
  endfunction

  task automatic model_reset();
    ap_q.delete();
    dp_has  = 1'b0;
    rsp_has = 1'b0;
    obs_err.delete();
    obs_write.delete();
    obs_rdata.delete();
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic [31:0] d);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_wdata = d;
  endtask

  task automatic set_bus(input logic rdy, input logic resp, input logic [31:0] rd);
    bus.HREADY = rdy;
    bus.HRESP  = resp;
    bus.HRDATA = rd;
  endtask

  // One clock: check what the bus shows now against the model, advance the model
  // by the AHB rules at the coming edge, then move to the next falling edge.
  task automatic step();
    cmd_t c;
    #1;
    chk("cmd_ready", bus.cmd_ready, bus.HREADY);
    chk("HTRANS", bus.HTRANS, (ap_q.size() > 0) ? 2'b10 : 2'b00);
    chk("busy", bus.busy, (ap_q.size() > 0) || dp_has);
    chk("HBURST", bus.HBURST, 3'b000);
    chk("HPROT", bus.HPROT, 4'b0011);
    chk("HMASTLOCK", bus.HMASTLOCK, 1'b0);
    if (ap_q.size() > 0) begin
      chk("HADDR", bus.HADDR, ap_q[0].addr);
      chk("HWRITE", bus.HWRITE, ap_q[0].write);
      chk("HSIZE", bus.HSIZE, exp_hsize(ap_q[0].size));
    end
    if (dp_has && dp_cmd.write)
      chk("HWDATA", bus.HWDATA, lanes(dp_cmd.size, dp_cmd.wdata));
    chk("rsp_valid", bus.rsp_valid, rsp_has);
    if (rsp_has) begin
      chk("rsp_write", bus.rsp_write, rsp_w);
      chk("rsp_err", bus.rsp_err, rsp_e);
      chk("rsp_rdata", bus.rsp_rdata, rsp_d);
    end
    if (bus.rsp_valid) begin
      obs_err.push_back(bus.rsp_err);
      obs_write.push_back(bus.rsp_write);
      obs_rdata.push_back(bus.rsp_rdata);
      last_rsp = step_no;
    end
    if (bus.HREADY) begin
      rsp_has = dp_has;
      if (dp_has) begin
        rsp_w = dp_cmd.write;
        rsp_e = bus.HRESP;
        rsp_d = dp_cmd.write ? 32'h0 : extract(dp_cmd.size, dp_cmd.addr, bus.HRDATA);
      end
      dp_has = (ap_q.size() > 0);
      if (dp_has) dp_cmd = ap_q.pop_front();
      if (bus.cmd_valid) begin
        c = '{write: bus.cmd_write, addr: bus.cmd_addr, size: bus.cmd_size, wdata: bus.cmd_wdata};
        ap_q.push_back(c);
        if (first_acc < 0) first_acc = step_no;
      end
    end else begin
      rsp_has = 1'b0;
    end
    @(posedge HCLK);
    @(negedge HCLK);
    step_no++;
  endtask

  task automatic check_reset();
    chk("rst_HTRANS", bus.HTRANS, 2'b00);
    chk("rst_HADDR", bus.HADDR, 32'h0);
    chk("rst_HWRITE", bus.HWRITE, 1'b0);
    chk("rst_HSIZE", bus.HSIZE, 3'b000);
    chk("rst_HWDATA", bus.HWDATA, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_write", bus.rsp_write, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
  endtask

  initial begin
    int   idx;
    logic err_next;
    logic rdy;
    bit   rd_hready[9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};

    step_no   = 0;
    first_acc = -1;
    last_rsp  = -1;
    HRESETn   = 1'b0;
    set_cmd(0, 0, 32'h0, 2'b00, 32'h0);
    set_bus(1, 0, 32'h0);
    model_reset();
    repeat (2) @(negedge HCLK);
    #1;
    check_reset();
    HRESETn = 1'b1;
    repeat (3) step();

    // Word write, zero wait
    model_reset();
    set_cmd(1, 1, 32'h0000_0010, 2'b10, 32'hDEAD_BEEF);
    step();
    set_cmd(0, 0, 32'h0, 2'b00, 32'h0);
    repeat (4) step();
    chk("ww_rsp_count", obs_err.size(), 1);
    chk("ww_rsp_write", obs_write[0], 1'b1);
    chk("ww_rsp_err", obs_err[0], 1'b0);

    // Byte write then byte read of the same address
    model_reset();
    set_bus(1, 0, 32'hA500_0000);
    set_cmd(1, 1, 32'h0000_0013, 2'b00, 32'h0000_00A5);
    step();
    set_cmd(1, 0, 32'h0000_0013, 2'b00, 32'h0);
    step();
    chk("bw_HWDATA", bus.HWDATA, 32'hA5A5_A5A5);
    set_cmd(0, 0, 32'h0, 2'b00, 32'h0);
    repeat (4) step();
    chk("br_rsp_count", obs_rdata.size(), 2);
    chk("br_rdata", obs_rdata[1], 32'h0000_00A5);

    // Four back-to-back word reads, two wait states in the second data phase
    model_reset();
    first_acc = -1;
    idx = 0;
    for (int i = 0; i < 9; i++) begin
      rdy = rd_hready[i];
      set_bus(rdy, 0, $urandom);
      if (idx < 4) set_cmd(1, 0, 32'h0000_0100 + 32'(idx * 4), 2'b10, 32'h0);
      else         set_cmd(0, 0, 32'h0, 2'b00, 32'h0);
      if (rdy && idx < 4) idx++;
      step();
    end
    set_bus(1, 0, 32'h0);
    set_cmd(0, 0, 32'h0, 2'b00, 32'h0);
    repeat (3) step();
    chk("rd4_rsp_count", obs_err.size(), 4);
    chk("rd4_total_cycles", last_rsp - first_acc, 8);

    // Halfword read from the upper half
    model_reset();
    set_bus(1, 0, 32'h1234_5678);
    set_cmd(1, 0, 32'h0000_0022, 2'b01, 32'h0);
    step();
    set_cmd(0, 0, 32'h0, 2'b00, 32'h0);
    repeat (4) step();
    chk("hw_rsp_count", obs_rdata.size(), 1);
    chk("hw_rdata", obs_rdata[0], 32'h0000_1234);

    // Two-cycle ERROR on a write with a read queued behind it
    model_reset();
    set_bus(1, 0, 32'hCAFE_F00D);
    set_cmd(1, 1, 32'h0000_0040, 2'b10, 32'h1111_2222);
    step();
    set_cmd(1, 0, 32'h0000_0044, 2'b10, 32'h0);
    step();
    set_cmd(0, 0, 32'h0, 2'b00, 32'h0);
    set_bus(0, 1, 32'hCAFE_F00D);
    step();
    set_bus(1, 1, 32'hCAFE_F00D);
    step();
    set_bus(1, 0, 32'hCAFE_F00D);
    repeat (4) step();
    chk("err_rsp_count", obs_err.size(), 2);
    chk("err_write_err", obs_err[0], 1'b1);
    chk("err_read_err", obs_err[1], 1'b0);
    chk("err_read_data", obs_rdata[1], 32'hCAFE_F00D);

    // Reset with two commands in flight
    model_reset();
    set_cmd(1, 1, 32'h0000_0080, 2'b10, 32'h5555_AAAA);
    step();
    set_cmd(1, 0, 32'h0000_0084, 2'b10, 32'h0);
    step();
    set_cmd(0, 0, 32'h0, 2'b00, 32'h0);
    #2;
    HRESETn = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (4) step();
    chk("rst_rsp_count", obs_err.size(), 0);

    // Random traffic with wait states and two-cycle errors
    model_reset();
    err_next = 1'b0;
    for (int i = 0; i < 500; i++) begin
      set_cmd($urandom_range(1), $urandom_range(1), $urandom, 2'($urandom_range(3)), $urandom);
      if (err_next) begin
        set_bus(1, 1, $urandom);
        err_next = 1'b0;
      end else if (dp_has && $urandom_range(7) == 0) begin
        set_bus(0, 1, $urandom);
        err_next = 1'b1;
      end else begin
        set_bus($urandom_range(3) != 0, 0, $urandom);
      end
      step();
    end
    set_cmd(0, 0, 32'h0, 2'b00, 32'h0);
    set_bus(1, 0, 32'h0);
    repeat (4) step();
    chk("rand_drained_busy", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
